pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter ALUC_W, default 4, alucontrol width; SHALL be >= 4, upper bits zero-filled.
REQ-002 Parameter EN_JUMP, default 1; 1 decodes jal/jalr, 0 flags them illegal.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 op_d  in  7  opcode of instruction in decode.
REQ-006 funct3_d  in  3  funct3 in decode.
REQ-007 funct7b5_d  in  1  instruction bit 30 in decode.
REQ-008 stall_d  in  1  hazard stall; inserts bubble into execute.
REQ-009 flush_e  in  1  squash of the instruction entering execute.
REQ-010 zero_e  in  1  ALU result zero, execute stage.
REQ-011 lt_e  in  1  signed less-than from ALU, execute stage.
REQ-012 immsrc_d  out  3  immediate format (I=000,S=001,B=010,J=011,U=100), combinational.
REQ-013 illegal_d  out  1  undecodable opcode/funct, combinational.
REQ-014 alucontrol_e  out  ALUC_W;  alusrc_e  out  1;  resultsrc_e  out  2 (00 ALU, 01 mem, 10 pc+4).
REQ-015 pcsrc_e  out  1  redirect PC;  jalr_e  out  1  target from ALU, not pc+imm.
REQ-016 memwrite_m  out  1;  regwrite_m  out  1;  regwrite_w  out  1;  resultsrc_w  out  2;  illegal_w  out  1.

Function
REQ-017 Decode SHALL cover R(0110011), I-ALU(0010011), load(0000011), store(0100011), branch(1100011), lui(0110111), jal(1101111), jalr(1100111).
REQ-018 ALU codes: ADD 0,SUB 1,AND 2,OR 3,XOR 4,SLT 5,SLL 6,SRL 7,SRA 8,SLTU 9,PASSB 10.
REQ-019 SUB only for R-type with funct7b5_d=1 and funct3=000; SRA for funct3=101, funct7b5_d=1 (R and I).
REQ-020 Loads/stores/jalr SHALL use ADD; branches SUB; lui PASSB with alusrc=1.
REQ-021 Illegal opcode, or branch funct3 010/011: illegal_d=1 and all control outputs of that instruction forced 0.
REQ-022 Decode-to-execute latency 1 cycle, to memory 2, to writeback 3.
REQ-023 ID/EX register SHALL load a bubble (all zero) when stall_d=1 or flush_e=1; flush_e has priority, identical result.
REQ-024 EX/MEM and MEM/WB registers SHALL advance every cycle, never stall.
REQ-025 pcsrc_e = jump_e OR (branch_e AND cond); cond: beq zero_e, bne !zero_e, blt lt_e, bge !lt_e, others 0.
REQ-026 jalr_e=1 only for jalr in execute; pcsrc_e=1 with it.
REQ-027 Bubble SHALL give pcsrc_e=0, regwrite and memwrite 0 in all downstream stages.
REQ-028 funct3 SHALL be registered into execute for branch-condition evaluation.

Reset
REQ-029 rst=1 at a rising edge SHALL clear all pipeline registers; every registered output reads 0 the next cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight instructions; no write enables asserted until a new instruction propagates.
REQ-031 Combinational outputs (immsrc_d, illegal_d) SHALL depend only on decode inputs, not on rst.

Structure
REQ-032 Shared package ctrl_pkg holds opcode constants, ALU code constants, immsrc/resultsrc encodings and the ID/EX control struct.
REQ-033 One combinational sub-module ctrl_decoder (op, funct3, funct7b5 -> control bundle, illegal); the top holds the three pipeline registers and branch logic.

Verification
REQ-034 add (op 0110011, f3 000, b5 0) -> alucontrol_e=0 at cycle+1, regwrite_w=1 at cycle+3, resultsrc_w=00.
REQ-035 beq with zero_e=1 -> pcsrc_e=1; same with zero_e=0 -> pcsrc_e=0; bge with lt_e=0 -> pcsrc_e=1.
REQ-036 lw then stall_d=1 for one cycle -> bubble: alucontrol_e=0, regwrite_m=0 next cycle, memwrite_m=0.
REQ-037 flush_e=1 together with sw in decode -> memwrite_m stays 0 two cycles later.
REQ-038 op 1111111 -> illegal_d=1, illegal_w=1 after 3 cycles, regwrite_w=0; EN_JUMP=0 with jal -> illegal_d=1.
REQ-039 rst pulse while sw in execute -> memwrite_m=0 next cycle, all registered outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode constants and pipeline control bundle for the RV32I control unit.
// Opcodes, ALU operation codes, immediate/result-select encodings and the ID/EX struct.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam int ALU_BASE_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_sel_e;

    // All-zero value of this struct is the pipeline bubble.
    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        res_sel_e   resultsrc;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        alu_op_e    alucontrol;
        logic [2:0] funct3;
        logic       illegal;
    } idex_ctrl_t;

    // SUB exists only for R-type; SRA is selected by bit 30 for both R and I shifts.
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic b5,
                                               input logic is_r);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_r && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Decode-side inputs and per-stage control outputs of the pipeline control unit.
interface pipe_control_unit_if #(parameter int ALUC_W = 4);

    logic [6:0]        op_d;
    logic [2:0]        funct3_d;
    logic              funct7b5_d;
    logic              stall_d;
    logic              flush_e;
    logic              zero_e;
    logic              lt_e;

    logic [2:0]        immsrc_d;
    logic              illegal_d;
    logic [ALUC_W-1:0] alucontrol_e;
    logic              alusrc_e;
    logic [1:0]        resultsrc_e;
    logic              pcsrc_e;
    logic              jalr_e;
    logic              memwrite_m;
    logic              regwrite_m;
    logic              regwrite_w;
    logic [1:0]        resultsrc_w;
    logic              illegal_w;

    modport master (
        output op_d, funct3_d, funct7b5_d, stall_d, flush_e, zero_e, lt_e,
        input  immsrc_d, illegal_d, alucontrol_e, alusrc_e, resultsrc_e, pcsrc_e, jalr_e,
        input  memwrite_m, regwrite_m, regwrite_w, resultsrc_w, illegal_w
    );

    modport slave (
        input  op_d, funct3_d, funct7b5_d, stall_d, flush_e, zero_e, lt_e,
        output immsrc_d, illegal_d, alucontrol_e, alusrc_e, resultsrc_e, pcsrc_e, jalr_e,
        output memwrite_m, regwrite_m, regwrite_w, resultsrc_w, illegal_w
    );

endinterface

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction decoder: opcode/funct fields to the ID/EX control bundle.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       [6:0] op,
    input  logic       [2:0] funct3,
    input  logic             funct7b5,
    output idex_ctrl_t       ctrl,
    output imm_sel_e         immsrc,
    output logic             illegal
);

    always_comb begin
        ctrl        = '0;
        immsrc      = IMM_I;
        illegal     = 1'b0;
        ctrl.funct3 = funct3;
        case (op)
            OP_R: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alucontrol = alu_from_funct(funct3, funct7b5, 1'b1);
            end
            OP_I: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = alu_from_funct(funct3, funct7b5, 1'b0);
            end
            OP_LOAD: begin
                ctrl.regwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.resultsrc = RES_MEM;
            end
            OP_STORE: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                immsrc        = IMM_S;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.branch     = 1'b1;
                    ctrl.alucontrol = ALU_SUB;
                    immsrc          = IMM_B;
                end
            end
            OP_LUI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = ALU_PASSB;
                immsrc          = IMM_U;
            end
            OP_JAL: begin
                if (EN_JUMP) begin
                    ctrl.regwrite  = 1'b1;
                    ctrl.jump      = 1'b1;
                    ctrl.resultsrc = RES_PC4;
                    immsrc         = IMM_J;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (EN_JUMP) begin
                    ctrl.regwrite  = 1'b1;
                    ctrl.jump      = 1'b1;
                    ctrl.jalr      = 1'b1;
                    ctrl.alusrc    = 1'b1;
                    ctrl.resultsrc = RES_PC4;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // An undecodable instruction must not leave any enable or select behind.
        if (illegal) begin
            ctrl   = '0;
            immsrc = IMM_I;
        end
        ctrl.illegal = illegal;
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decoder plus ID/EX, EX/MEM and MEM/WB control registers
// and the execute-stage branch/jump redirect.
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUC_W  = 4,
    parameter bit EN_JUMP = 1'b1
) (
    input logic              clk,
    input logic              rst,
    pipe_control_unit_if.slave bus
);

    typedef struct packed {
        logic     regwrite;
        logic     memwrite;
        res_sel_e resultsrc;
        logic     illegal;
    } exmem_t;

    typedef struct packed {
        logic     regwrite;
        res_sel_e resultsrc;
        logic     illegal;
    } memwb_t;

    idex_ctrl_t dec_ctrl;
    imm_sel_e   dec_imm;
    logic       dec_illegal;

    idex_ctrl_t idex_reg, idex_next;
    exmem_t     exmem_reg, exmem_next;
    memwb_t     memwb_reg, memwb_next;
    logic       cond_taken;

    ctrl_decoder #(.EN_JUMP(EN_JUMP)) u_dec (
        .op       (bus.op_d),
        .funct3   (bus.funct3_d),
        .funct7b5 (bus.funct7b5_d),
        .ctrl     (dec_ctrl),
        .immsrc   (dec_imm),
        .illegal  (dec_illegal)
    );

    always_comb begin
        if (bus.flush_e || bus.stall_d) begin
            idex_next = '0;
        end else begin
            idex_next = dec_ctrl;
        end
        exmem_next = '{regwrite: idex_reg.regwrite, memwrite: idex_reg.memwrite,
                       resultsrc: idex_reg.resultsrc, illegal: idex_reg.illegal};
        memwb_next = '{regwrite: exmem_reg.regwrite, resultsrc: exmem_reg.resultsrc,
                       illegal: exmem_reg.illegal};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_reg  <= '0;
            exmem_reg <= '0;
            memwb_reg <= '0;
        end else begin
            idex_reg  <= idex_next;
            exmem_reg <= exmem_next;
            memwb_reg <= memwb_next;
        end
    end

    // Unsigned branches (bltu/bgeu) are decoded but never redirect here.
    always_comb begin
        case (idex_reg.funct3)
            F3_BEQ:  cond_taken = bus.zero_e;
            F3_BNE:  cond_taken = !bus.zero_e;
            F3_BLT:  cond_taken = bus.lt_e;
            F3_BGE:  cond_taken = !bus.lt_e;
            default: cond_taken = 1'b0;
        endcase
    end

    logic [ALU_BASE_W-1:0] aluc_base;
    logic [ALUC_W-1:0]     aluc_ext;
    assign aluc_base = idex_reg.alucontrol;

    for (genvar gi = 0; gi < ALUC_W; gi++) begin : g_aluc
        if (gi < ALU_BASE_W) begin : g_lo
            assign aluc_ext[gi] = aluc_base[gi];
        end else begin : g_hi
            assign aluc_ext[gi] = 1'b0;
        end
    end

    assign bus.immsrc_d     = dec_imm;
    assign bus.illegal_d    = dec_illegal;
    assign bus.alucontrol_e = aluc_ext;
    assign bus.alusrc_e     = idex_reg.alusrc;
    assign bus.resultsrc_e  = idex_reg.resultsrc;
    assign bus.pcsrc_e      = idex_reg.jump | (idex_reg.branch & cond_taken);
    assign bus.jalr_e       = idex_reg.jalr;
    assign bus.memwrite_m   = exmem_reg.memwrite;
    assign bus.regwrite_m   = exmem_reg.regwrite;
    assign bus.regwrite_w   = memwb_reg.regwrite;
    assign bus.resultsrc_w  = memwb_reg.resultsrc;
    assign bus.illegal_w    = memwb_reg.illegal;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: expected stage records are queued when an
// instruction is driven into decode and compared when each stage should show it.
module tb_pipe_control_unit;

    localparam int ALUC_W = 6;

    typedef struct {
        int         due;
        logic [6:0] op;
        logic [2:0] f3;
        logic       b5;
        logic       zero;
        logic       lt;
        logic [2:0] imm;
        logic       ill;
        logic [3:0] alu;
        logic       asrc;
        logic [1:0] rs;
        logic       rw;
        logic       mw;
        logic       jr;
        logic       pc;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic pend_zero = 1'b0;
    logic pend_lt = 1'b0;
    ins_t e_q[$];
    ins_t m_q[$];
    ins_t w_q[$];

    pipe_control_unit_if #(.ALUC_W(ALUC_W)) bus ();
    pipe_control_unit_if #(.ALUC_W(ALUC_W)) bus_nj ();

    pipe_control_unit #(.ALUC_W(ALUC_W), .EN_JUMP(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_control_unit #(.ALUC_W(ALUC_W), .EN_JUMP(1'b0)) dut_nj (
        .clk (clk),
        .rst (rst),
        .bus (bus_nj)
    );

    assign bus_nj.op_d       = bus.op_d;
    assign bus_nj.funct3_d   = bus.funct3_d;
    assign bus_nj.funct7b5_d = bus.funct7b5_d;
    assign bus_nj.stall_d    = bus.stall_d;
    assign bus_nj.flush_e    = bus.flush_e;
    assign bus_nj.zero_e     = bus.zero_e;
    assign bus_nj.lt_e       = bus.lt_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ins_t mk(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                                input logic z, input logic l, input logic [2:0] imm,
                                input logic ill, input logic [3:0] alu, input logic asrc,
                                input logic [1:0] rs, input logic rw, input logic mw,
                                input logic jr, input logic pc);
        ins_t r;
        r.due = 0; r.op = op; r.f3 = f3; r.b5 = b5; r.zero = z; r.lt = l;
        r.imm = imm; r.ill = ill; r.alu = alu; r.asrc = asrc; r.rs = rs;
        r.rw = rw; r.mw = mw; r.jr = jr; r.pc = pc;
        return r;
    endfunction

    function automatic ins_t bubble();
        return mk(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 2'd0,
                  1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Common instructions with hand-derived expected control values.
    function automatic ins_t i_nop();  return mk(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
    function automatic ins_t i_add();  return mk(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
    function automatic ins_t i_lw();   return mk(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
    function automatic ins_t i_sw();   return mk(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); endfunction
    function automatic ins_t i_br(input logic [2:0] f3, input logic z, input logic l, input logic pc);
        return mk(7'b1100011, f3, 1'b0, z, l, 3'b010, 1'b0, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pc);
    endfunction
    function automatic ins_t i_bad(input logic [6:0] op, input logic [2:0] f3);
        return mk(op, f3, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Drives one decode slot and queues what each later stage must show for it.
    task automatic apply(input ins_t d, input logic stall, input logic flush, input logic do_rst);
        ins_t b;
        bus.op_d       = d.op;
        bus.funct3_d   = d.f3;
        bus.funct7b5_d = d.b5;
        bus.stall_d    = stall;
        bus.flush_e    = flush;
        rst            = do_rst;
        bus.zero_e     = pend_zero;
        bus.lt_e       = pend_lt;
        pend_zero      = d.zero;
        pend_lt        = d.lt;
        if (stall || flush || do_rst) b = bubble();
        else b = d;
        if (do_rst) begin
            while (e_q.size() > 0 && e_q[$].due > cyc) void'(e_q.pop_back());
            while (m_q.size() > 0 && m_q[$].due > cyc) void'(m_q.pop_back());
            while (w_q.size() > 0 && w_q[$].due > cyc) void'(w_q.pop_back());
            for (int k = 1; k <= 3; k++) begin
                b.due = cyc + k;
                if (k == 1) e_q.push_back(b);
                if (k <= 2) m_q.push_back(b);
                w_q.push_back(b);
            end
        end else begin
            b.due = cyc + 1; e_q.push_back(b);
            b.due = cyc + 2; m_q.push_back(b);
            b.due = cyc + 3; w_q.push_back(b);
        end
        $display("cyc %0d op=%b f3=%b b5=%b zero_e=%b lt_e=%b stall=%b flush=%b rst=%b",
                 cyc, d.op, d.f3, d.b5, bus.zero_e, bus.lt_e, stall, flush, do_rst);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_monitor();
        ins_t r;
        logic [ALUC_W-1:0] ea;
        forever begin
            @(negedge clk);
            if (e_q.size() > 0 && e_q[0].due == cyc) begin
                r = e_q.pop_front();
                ea = '0;
                ea[3:0] = r.alu;
                compared++; if (bus.alucontrol_e !== ea) begin mismatched++; $display("FAIL e_alucontrol cyc=%0d got=%h want=%h", cyc, bus.alucontrol_e, ea); end
                compared++; if (bus.alusrc_e !== r.asrc) begin mismatched++; $display("FAIL e_alusrc cyc=%0d got=%b want=%b", cyc, bus.alusrc_e, r.asrc); end
                compared++; if (bus.resultsrc_e !== r.rs) begin mismatched++; $display("FAIL e_resultsrc cyc=%0d got=%b want=%b", cyc, bus.resultsrc_e, r.rs); end
                compared++; if (bus.jalr_e !== r.jr) begin mismatched++; $display("FAIL e_jalr cyc=%0d got=%b want=%b", cyc, bus.jalr_e, r.jr); end
                compared++; if (bus.pcsrc_e !== r.pc) begin mismatched++; $display("FAIL e_pcsrc cyc=%0d got=%b want=%b", cyc, bus.pcsrc_e, r.pc); end
            end
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                r = m_q.pop_front();
                compared++; if (bus.memwrite_m !== r.mw) begin mismatched++; $display("FAIL m_memwrite cyc=%0d got=%b want=%b", cyc, bus.memwrite_m, r.mw); end
                compared++; if (bus.regwrite_m !== r.rw) begin mismatched++; $display("FAIL m_regwrite cyc=%0d got=%b want=%b", cyc, bus.regwrite_m, r.rw); end
            end
            if (w_q.size() > 0 && w_q[0].due == cyc) begin
                r = w_q.pop_front();
                compared++; if (bus.regwrite_w !== r.rw) begin mismatched++; $display("FAIL w_regwrite cyc=%0d got=%b want=%b", cyc, bus.regwrite_w, r.rw); end
                compared++; if (bus.resultsrc_w !== r.rs) begin mismatched++; $display("FAIL w_resultsrc cyc=%0d got=%b want=%b", cyc, bus.resultsrc_w, r.rs); end
                compared++; if (bus.illegal_w !== r.ill) begin mismatched++; $display("FAIL w_illegal cyc=%0d got=%b want=%b", cyc, bus.illegal_w, r.ill); end
            end
        end
    endtask

    task automatic test_reset();
        ins_t d;
        d = i_sw();
        apply(d, 1'b0, 1'b0, 1'b1);
        compared++; if (bus.immsrc_d !== 3'b001) begin mismatched++; $display("FAIL rst_immsrc_d got=%b want=001", bus.immsrc_d); end
        tick();
        compared++; if ({bus.alucontrol_e, bus.alusrc_e, bus.resultsrc_e, bus.pcsrc_e, bus.jalr_e} !== '0) begin mismatched++; $display("FAIL rst_e_outputs got=%h want=0", {bus.alucontrol_e, bus.alusrc_e, bus.resultsrc_e, bus.pcsrc_e, bus.jalr_e}); end
        compared++; if ({bus.memwrite_m, bus.regwrite_m, bus.regwrite_w, bus.resultsrc_w, bus.illegal_w} !== '0) begin mismatched++; $display("FAIL rst_mw_outputs got=%h want=0", {bus.memwrite_m, bus.regwrite_m, bus.regwrite_w, bus.resultsrc_w, bus.illegal_w}); end
    endtask

    task automatic test_alu();
        ins_t t[14];
        t[0]  = i_add();
        t[1]  = mk(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 4'd1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[2]  = mk(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd6, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[3]  = mk(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[4]  = mk(7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd9, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[5]  = mk(7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[6]  = mk(7'b0110011, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd7, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[7]  = mk(7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 4'd8, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[8]  = mk(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[9]  = mk(7'b0110011, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 4'd2, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[10] = mk(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[11] = mk(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[12] = mk(7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd9, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        t[13] = mk(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 4'd10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            apply(t[i], 1'b0, 1'b0, 1'b0);
            compared++; if (bus.immsrc_d !== t[i].imm) begin mismatched++; $display("FAIL alu_immsrc_d idx=%0d got=%b want=%b", i, bus.immsrc_d, t[i].imm); end
            compared++; if (bus.illegal_d !== 1'b0) begin mismatched++; $display("FAIL alu_illegal_d idx=%0d got=%b want=0", i, bus.illegal_d); end
            tick();
        end
    endtask

    task automatic test_branch();
        ins_t t[10];
        t[0] = i_br(3'b000, 1'b1, 1'b0, 1'b1);
        t[1] = i_br(3'b000, 1'b0, 1'b0, 1'b0);
        t[2] = i_br(3'b001, 1'b0, 1'b1, 1'b1);
        t[3] = i_br(3'b001, 1'b1, 1'b0, 1'b0);
        t[4] = i_br(3'b100, 1'b0, 1'b1, 1'b1);
        t[5] = i_br(3'b100, 1'b1, 1'b0, 1'b0);
        t[6] = i_br(3'b101, 1'b0, 1'b0, 1'b1);
        t[7] = i_br(3'b101, 1'b0, 1'b1, 1'b0);
        t[8] = i_br(3'b110, 1'b1, 1'b1, 1'b0);
        t[9] = i_br(3'b111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(t[i], 1'b0, 1'b0, 1'b0);
            compared++; if (bus.immsrc_d !== 3'b010) begin mismatched++; $display("FAIL br_immsrc_d idx=%0d got=%b want=010", i, bus.immsrc_d); end
            tick();
        end
    endtask

    task automatic test_jump();
        ins_t t[2];
        t[0] = mk(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 4'd0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
        t[1] = mk(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            apply(t[i], 1'b0, 1'b0, 1'b0);
            compared++; if (bus.immsrc_d !== t[i].imm) begin mismatched++; $display("FAIL jmp_immsrc_d idx=%0d got=%b want=%b", i, bus.immsrc_d, t[i].imm); end
            compared++; if (bus_nj.illegal_d !== 1'b1) begin mismatched++; $display("FAIL nojump_illegal_d idx=%0d got=%b want=1", i, bus_nj.illegal_d); end
            compared++; if (bus_nj.immsrc_d !== 3'b000) begin mismatched++; $display("FAIL nojump_immsrc_d idx=%0d got=%b want=000", i, bus_nj.immsrc_d); end
            tick();
        end
    endtask

    task automatic test_stall();
        apply(i_lw(), 1'b0, 1'b0, 1'b0);
        tick();
        apply(i_sw(), 1'b1, 1'b0, 1'b0);
        tick();
        compared++; if (bus.alucontrol_e !== '0 || bus.alusrc_e !== 1'b0) begin mismatched++; $display("FAIL stall_e_bubble got=%h/%b want=0/0", bus.alucontrol_e, bus.alusrc_e); end
        apply(i_sw(), 1'b0, 1'b0, 1'b0);
        tick();
        compared++; if (bus.regwrite_m !== 1'b0 || bus.memwrite_m !== 1'b0) begin mismatched++; $display("FAIL stall_m_bubble got=%b/%b want=0/0", bus.regwrite_m, bus.memwrite_m); end
        apply(i_nop(), 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        apply(i_sw(), 1'b0, 1'b1, 1'b0);
        tick();
        apply(i_add(), 1'b1, 1'b1, 1'b0);
        tick();
        compared++; if (bus.memwrite_m !== 1'b0) begin mismatched++; $display("FAIL flush_memwrite_m got=%b want=0", bus.memwrite_m); end
        apply(i_br(3'b000, 1'b1, 1'b0, 1'b1), 1'b0, 1'b1, 1'b0);
        tick();
        compared++; if (bus.pcsrc_e !== 1'b0) begin mismatched++; $display("FAIL flush_pcsrc_e got=%b want=0", bus.pcsrc_e); end
    endtask

    task automatic test_illegal();
        ins_t t[4];
        t[0] = i_bad(7'b1111111, 3'b000);
        t[1] = i_bad(7'b1100011, 3'b010);
        t[2] = i_bad(7'b1100011, 3'b011);
        t[3] = i_bad(7'b0000000, 3'b010);
        for (int i = 0; i < 4; i++) begin
            apply(t[i], 1'b0, 1'b0, 1'b0);
            compared++; if (bus.illegal_d !== 1'b1) begin mismatched++; $display("FAIL ill_illegal_d idx=%0d got=%b want=1", i, bus.illegal_d); end
            compared++; if (bus.immsrc_d !== 3'b000) begin mismatched++; $display("FAIL ill_immsrc_d idx=%0d got=%b want=000", i, bus.immsrc_d); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        apply(i_sw(), 1'b0, 1'b0, 1'b0);
        tick();
        apply(i_lw(), 1'b0, 1'b0, 1'b1);
        tick();
        compared++; if (bus.memwrite_m !== 1'b0) begin mismatched++; $display("FAIL midrst_memwrite_m got=%b want=0", bus.memwrite_m); end
        compared++; if ({bus.alucontrol_e, bus.alusrc_e, bus.resultsrc_e, bus.regwrite_m, bus.regwrite_w} !== '0) begin mismatched++; $display("FAIL midrst_outputs got=%h want=0", {bus.alucontrol_e, bus.alusrc_e, bus.resultsrc_e, bus.regwrite_m, bus.regwrite_w}); end
    endtask

    task automatic test_back_to_back();
        apply(i_add(), 1'b0, 1'b0, 1'b0); tick();
        apply(mk(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 4'd0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0); tick();
        apply(i_br(3'b000, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0); tick();
        apply(i_sw(), 1'b0, 1'b0, 1'b0); tick();
        apply(i_lw(), 1'b0, 1'b0, 1'b0); tick();
        compared++; if (bus.memwrite_m !== 1'b1) begin mismatched++; $display("FAIL b2b_memwrite_m got=%b want=1", bus.memwrite_m); end
        apply(i_bad(7'b1111111, 3'b000), 1'b0, 1'b0, 1'b0); tick();
    endtask

    initial begin
        bus.op_d = '0; bus.funct3_d = '0; bus.funct7b5_d = 1'b0;
        bus.stall_d = 1'b0; bus.flush_e = 1'b0; bus.zero_e = 1'b0; bus.lt_e = 1'b0;
        fork
            sb_monitor();
        join_none
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_midflight();
        test_back_to_back();
        repeat (4) @(negedge clk);
        #1;
        compared++;
        if (e_q.size() + m_q.size() + w_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain got=%0d left want=0", e_q.size() + m_q.size() + w_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
